// File: rtl/dou_pack_24_8.sv
// dou_pack_24_8: packs pairs of signed activation bytes (a, b) into one
// 24-bit signed operand a*2^16 + b, so a single 24x8 multiply against a
// shared weight produces two 16-bit products. Valid/ready on both sides,
// single-entry output register, per-frame count of emitted words.
module dou_pack_24_8 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [23:0]      out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic [CNT_W-1:0] pair_cnt
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      HOLD_A = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic signed [7:0]  in_s;
   logic signed [7:0]  a_p0;
   logic signed [7:0]  word_a;
   logic signed [7:0]  word_b;
   logic               word_last;
   logic               word_fire;
   logic               a_cap;
   logic               in_xfer;
   logic               out_xfer;
   logic signed [23:0] packed_w;

   // Sign-extend both bytes and form a*2^16 + b modulo 2^24; the upper byte
   // absorbs the borrow when b is negative.
   function automatic logic signed [23:0] pack(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
      logic signed [23:0] ax;
      logic signed [23:0] bx;
      ax = {{16{a[7]}}, a};
      bx = {{16{b[7]}}, b};
      return (ax <<< 16) + bx;
   endfunction

   assign in_s     = in_data;
   // A new word may load whenever the register is empty or being drained.
   assign in_ready = !out_valid || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign packed_w = pack(word_a, word_b);

   // State register; reset discards any half-built pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and selection of the operands for a completed word.
   always_comb begin
      state_d   = state_q;
      word_fire = 1'b0;
      a_cap     = 1'b0;
      word_a    = '0;
      word_b    = '0;
      word_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               if (in_last) begin
                  // Lone final byte of an odd-length frame pairs with zero.
                  word_fire = 1'b1;
                  word_a    = in_s;
                  word_b    = '0;
                  word_last = 1'b1;
               end else begin
                  a_cap   = 1'b1;
                  state_d = HOLD_A;
               end
            end
         end
         HOLD_A: begin
            if (in_xfer) begin
               word_fire = 1'b1;
               word_a    = a_p0;
               word_b    = in_s;
               word_last = in_last;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Held upper byte; only meaningful while in HOLD_A, so no reset needed.
   always_ff @(posedge clk) begin
      if (a_cap) begin
         a_p0 <= in_s;
      end
   end

   // Output register: reload on a new word (even while draining), else
   // clear valid once the current word has been taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (word_fire) begin
         out_valid <= 1'b1;
         out_data  <= packed_w;
         out_last  <= word_last;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

   // Per-frame word counter; closing a frame clears it ahead of incrementing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_cnt <= '0;
      end else if (out_xfer) begin
         if (out_last) begin
            pair_cnt <= '0;
         end else begin
            pair_cnt <= pair_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dou_pack_24_8.sv
// Bench for dou_pack_24_8: directed byte stimulus pushes hand-computed words
// into a scoreboard queue; an independent monitor pops and compares on each
// output transfer.
module tb_dou_pack_24_8;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic [15:0] pair_cnt;

   typedef struct {
      logic [23:0] d;
      logic        l;
      logic [15:0] c;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   stall_sum;
   int   w;

   dou_pack_24_8 #(.CNT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_ready(out_ready),
      .pair_cnt (pair_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_word(input logic [23:0] d, input logic l, input logic [15:0] c);
      exp_t e;
      e.d = d;
      e.l = l;
      e.c = c;
      exp_q.push_back(e);
   endtask

   // Offer one byte; returns the number of cycles it had to wait.
   task automatic send(input logic [7:0] d, input logic l, output int waited);
      logic acc;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      waited   = 0;
      forever begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         waited++;
         if (waited > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, waited %0d", d, waited);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: compare every output transfer against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%06h, expected none", out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("word_data", {8'h0, out_data}, {8'h0, e.d});
            check("word_last", {31'h0, out_last}, {31'h0, e.l});
            check("word_cnt", {16'h0, pair_cnt}, {16'h0, e.c});
         end
      end
   end

   logic [7:0] stream_b [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                                 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'd100, 8'h9C, 8'hCE, 8'd50};
   logic [23:0] stream_w [8] = '{24'h010002, 24'h030004, 24'h050006, 24'h070008,
                                 24'hFEFFFE, 24'hFCFFFC, 24'h63FF9C, 24'hCE0032};

   initial begin
      rst = 1'b1;
      in_data = '0;
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'h0, out_valid}, 0);
      check("rst_out_data", {8'h0, out_data}, 0);
      check("rst_out_last", {31'h0, out_last}, 0);
      check("rst_pair_cnt", {16'h0, pair_cnt}, 0);
      check("rst_in_ready", {31'h0, in_ready}, 1);
      @(posedge clk);
      #1;

      // Basic pair 3, -2
      send(8'd3, 1'b0, w);
      expect_word(24'h02FFFE, 1'b0, 16'd0);
      send(8'hFE, 1'b0, w);
      drain();
      check("basic_pair_cnt", {16'h0, pair_cnt}, 1);

      // Sign extremes, closing the frame on the last byte
      send(8'hFF, 1'b0, w);
      expect_word(24'hFEFFFF, 1'b0, 16'd1);
      send(8'hFF, 1'b0, w);
      send(8'h80, 1'b0, w);
      expect_word(24'h80007F, 1'b0, 16'd2);
      send(8'h7F, 1'b0, w);
      send(8'h7F, 1'b0, w);
      expect_word(24'h7EFF80, 1'b1, 16'd3);
      send(8'h80, 1'b1, w);
      drain();
      check("extremes_cnt_clear", {16'h0, pair_cnt}, 0);

      // Odd frame 1, 2, 5(last)
      send(8'd1, 1'b0, w);
      expect_word(24'h010002, 1'b0, 16'd0);
      send(8'd2, 1'b0, w);
      expect_word(24'h050000, 1'b1, 16'd1);
      send(8'd5, 1'b1, w);
      drain();
      check("odd_cnt_clear", {16'h0, pair_cnt}, 0);

      // Backpressure
      out_ready = 1'b0;
      send(8'd10, 1'b0, w);
      expect_word(24'h0A0014, 1'b0, 16'd0);
      send(8'd20, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_out_valid", {31'h0, out_valid}, 1);
         check("bp_out_data", {8'h0, out_data}, 32'h0A0014);
         check("bp_in_ready", {31'h0, in_ready}, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      expect_word(24'h1E0000, 1'b1, 16'd1);
      send(8'd30, 1'b1, w);
      check("bp_release_accept_wait", w, 0);
      drain();

      // Streaming 16 bytes back-to-back
      stall_sum = 0;
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 1) expect_word(stream_w[i/2], (i == 15), 16'(i/2));
         send(stream_b[i], (i == 15), w);
         stall_sum += w;
      end
      check("stream_no_stall", stall_sum, 0);
      drain();

      // Async reset in HOLD_A mid-frame
      send(8'd11, 1'b0, w);
      expect_word(24'h0B000C, 1'b0, 16'd0);
      send(8'd12, 1'b0, w);
      send(8'd9, 1'b0, w);
      drain();
      check("pre_rst_cnt", {16'h0, pair_cnt}, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'h0, out_valid}, 0);
      check("arst_out_data", {8'h0, out_data}, 0);
      check("arst_out_last", {31'h0, out_last}, 0);
      check("arst_pair_cnt", {16'h0, pair_cnt}, 0);
      check("arst_in_ready", {31'h0, in_ready}, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'd4, 1'b0, w);
      expect_word(24'h040006, 1'b0, 16'd0);
      send(8'd6, 1'b0, w);
      drain();
      check("post_rst_cnt", {16'h0, pair_cnt}, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dou_pack_24_8.md
# dou_pack_24_8

Operand packer for the dual-product multiplier path. It turns a stream of signed 8-bit activations into 24-bit packed operands, so that one 24x8 multiply against a shared 8-bit weight yields two 16-bit products, one in each half of the product. Byte pairs (a, b) from the activation stream become packed = a·2^16 + b, written as a 24-bit two's-complement value. The block sits between the feature-map line buffer and the packed multiplier, and uses valid/ready handshakes on both sides.

## Interface
- CNT_W, 16, width of the per-frame packed-word counter
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  signed activation byte
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  byte is the final byte of the frame
- in_ready  out  1  block accepts a byte this cycle
- out_data  out  24  packed operand, signed
- out_valid  out  1  out_data/out_last valid
- out_last  out  1  word carries the frame's final byte
- out_ready  in  1  downstream accepts a word this cycle
- pair_cnt  out  CNT_W  words emitted in current frame so far

## Operation
- An input byte transfers when in_valid & in_ready. An output word transfers when out_valid & out_ready.
- State machine:
  - IDLE: no byte held. An accepted byte without in_last is latched as a; go to HOLD_A. An accepted byte with in_last emits a word with a = byte, b = 0, out_last = 1, and stays in IDLE.
  - HOLD_A: the next accepted byte is b. Emit the word, with out_last = in_last, and go to IDLE.
- Packing, with a and b sign-extended to 24 bits: out_data = (a << 16) + b, modulo 2^24. Equivalently:
  - out_data[23:16] = a - (b < 0 ? 1 : 0)
  - out_data[15:0] = sign-extended b
- Output register: a single entry. in_ready = !out_valid | out_ready in every state, for simplicity. Sustained throughput is 1 byte/cycle in and 1 word per 2 cycles out.
- While out_valid = 1 and out_ready = 0, out_data and out_last stay stable.
- pair_cnt:
  - increments on each output transfer, wrapping at 2^CNT_W;
  - clears to 0 on the transfer of a word with out_last = 1 (the clear takes priority over the increment).
- in_last arriving in HOLD_A closes the frame normally; the next byte starts a new frame as a.
- Reset mid-frame: any held a is discarded and pair_cnt clears; no partial word is emitted.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_last = 0, pair_cnt = 0, state = IDLE. in_ready = 1 after reset, because out_valid = 0.
- Latency: out_valid rises the cycle after the edge that accepts b, or after the lone last byte in IDLE.
- A simultaneous output transfer and input transfer that completes a new word in the same cycle is legal. The register reloads, out_valid stays 1, and there is no bubble.
- in_valid with in_ready = 0 is ignored. The source holds its data.
- The count update on an output transfer is visible on pair_cnt the next cycle.

## Test plan
- Basic pair: bytes 3, -2 with out_ready = 1 -> out_data = 0x02FFFE, out_last = 0, pair_cnt = 1 one cycle after the word transfers.
- Sign extremes:
  - pair (-1, -1) -> 0xFEFFFF
  - pair (-128, 127) -> 0x80007F
  - pair (127, -128) -> 0x7EFF80
- Odd frame: bytes 1, 2, 5 with in_last on 5 -> words 0x010002 then 0x050000; the second has out_last = 1, and pair_cnt returns to 0 after it transfers.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with a word pending -> out_data stays stable and in_ready = 0.
  - Release -> the word transfers, and a byte offered in the same cycle is accepted.
- Streaming: 16 bytes back-to-back with out_ready = 1 -> 8 words, one every 2 cycles, correct values, no drops.
- Async reset asserted in HOLD_A mid-frame -> all outputs return to reset values immediately. The next bytes 4, 6 produce 0x040006 with pair_cnt counting from 0.
